// File: rtl/orb_bank_arbiter.sv
// orb_bank_arbiter
//   Round-robin write-port arbiter and ping-pong bank controller for the
//   two orbit frame RAMs. One single-word write is granted per cycle and
//   steered to the bank the M16 reader is not using. The reader's bank
//   flag (sw) is synchronised here; every edge swaps the write bank and
//   costs one bubble cycle.
//
//   Optional feature macro: BANK_CLEAR_EN
//     When defined, the write bank is swept to zero after reset and after
//     every swap; clrBusy is high while the sweep runs.
//
//   Ports
//     clk, rst              clock, asynchronous active-high reset
//     req                   per-requester write request (level)
//     reqAddr / reqWord     packed per-requester address / data
//     sw                    M16 read-bank flag (foreign clock domain)
//     gnt                   one-hot grant pulse, write issued this cycle
//     wData                 write data shared by both banks
//     wAddr1/wren1          bank 1 write port
//     wAddr2/wren2          bank 2 write port
//     wrBank                current write bank (1 = bank 1, 0 = bank 2)
//     swapStrob             pulse when the write bank changes
//     clrBusy               bank clear in progress
module orb_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 11,
  parameter int DW   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   reqAddr,
  input  logic [NREQ*DW-1:0]   reqWord,
  input  logic                 sw,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        wData,
  output logic [AW-1:0]        wAddr1,
  output logic                 wren1,
  output logic [AW-1:0]        wAddr2,
  output logic                 wren2,
  output logic                 wrBank,
  output logic                 swapStrob,
  output logic                 clrBusy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SWAP
`ifdef BANK_CLEAR_EN
    , ST_CLEAR
`endif
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [AW-1:0]   waddr1_q, waddr1_d, waddr2_q, waddr2_d;
  logic            wren1_q, wren1_d, wren2_q, wren2_d;
  logic            wr_bank_q, wr_bank_d;
  logic            swap_strob_q, swap_strob_d;
`ifdef BANK_CLEAR_EN
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            clr_busy_q, clr_busy_d;
`endif

  logic            sw_edge;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [PW-1:0]   win;
  int              idx;

  assign sw_edge = sync2_q ^ sync3_q;
  // A requester granted last cycle sits out this cycle.
  assign elig    = req & ~gnt_q;

  // First eligible index at or after ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sync1_d      = sw;
    sync2_d      = sync1_q;
    sync3_d      = sync2_q;
    ptr_d        = ptr_q;
    gnt_d        = '0;
    wdata_d      = wdata_q;
    waddr1_d     = waddr1_q;
    waddr2_d     = waddr2_q;
    wren1_d      = 1'b0;
    wren2_d      = 1'b0;
    wr_bank_d    = wr_bank_q;
    swap_strob_d = 1'b0;
`ifdef BANK_CLEAR_EN
    clr_cnt_d    = clr_cnt_q;
    clr_busy_d   = clr_busy_q;
`endif
    if (sw_edge) begin
      // Swap beats any win this cycle; the loser stays pending.
      swap_strob_d = 1'b1;
      wr_bank_d    = sync2_q;
      state_d      = ST_SWAP;
`ifdef BANK_CLEAR_EN
      clr_cnt_d    = '0;
      clr_busy_d   = 1'b1;
`endif
    end
`ifdef BANK_CLEAR_EN
    else if (state_q != ST_RUN) begin
      clr_busy_d = 1'b1;
      wdata_d    = '0;
      if (wr_bank_q) begin
        waddr1_d = clr_cnt_q;
        wren1_d  = 1'b1;
      end else begin
        waddr2_d = clr_cnt_q;
        wren2_d  = 1'b1;
      end
      if (clr_cnt_q == {AW{1'b1}}) begin
        state_d = ST_RUN;
      end else begin
        state_d   = ST_CLEAR;
        clr_cnt_d = clr_cnt_q + AW'(1);
      end
    end
`endif
    else if (state_q == ST_RUN || state_q == ST_SWAP) begin
      state_d = ST_RUN;
`ifdef BANK_CLEAR_EN
      clr_busy_d = 1'b0;
`endif
      if (found) begin
        gnt_d[win] = 1'b1;
        wdata_d    = reqWord[int'(win)*DW +: DW];
        if (wr_bank_q) begin
          waddr1_d = reqAddr[int'(win)*AW +: AW];
          wren1_d  = 1'b1;
        end else begin
          waddr2_d = reqAddr[int'(win)*AW +: AW];
          wren2_d  = 1'b1;
        end
        ptr_d = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef BANK_CLEAR_EN
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      clr_busy_q <= 1'b1;
`else
      state_q    <= ST_RUN;
`endif
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      ptr_q        <= '0;
      gnt_q        <= '0;
      wdata_q      <= '0;
      waddr1_q     <= '0;
      waddr2_q     <= '0;
      wren1_q      <= 1'b0;
      wren2_q      <= 1'b0;
      wr_bank_q    <= 1'b0;
      swap_strob_q <= 1'b0;
    end else begin
`ifdef BANK_CLEAR_EN
      clr_cnt_q  <= clr_cnt_d;
      clr_busy_q <= clr_busy_d;
`endif
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      wdata_q      <= wdata_d;
      waddr1_q     <= waddr1_d;
      waddr2_q     <= waddr2_d;
      wren1_q      <= wren1_d;
      wren2_q      <= wren2_d;
      wr_bank_q    <= wr_bank_d;
      swap_strob_q <= swap_strob_d;
    end
  end

  assign gnt       = gnt_q;
  assign wData     = wdata_q;
  assign wAddr1    = waddr1_q;
  assign wren1     = wren1_q;
  assign wAddr2    = waddr2_q;
  assign wren2     = wren2_q;
  assign wrBank    = wr_bank_q;
  assign swapStrob = swap_strob_q;
`ifdef BANK_CLEAR_EN
  assign clrBusy   = clr_busy_q;
`else
  assign clrBusy   = 1'b0;
`endif

endmodule
